cache_store_l1_data: RTL and testbench
======================================

# cache_store_l1_data

Store-side counterpart of the L1 load data extractor: accepts one RISC-V store (SB/SH/SW/SD), performs a read-modify-write of the addressed 128-bit L1 data block, and writes back the merged block with per-byte enables. Sits between the core's store port and the L1 data array.
- Byte placement inside the block mirrors the load path's `word_i`/`offset_i` decoding, so a store followed by the matching load returns the stored value.

## Interface
Parameters
- `offset_size`, 2: byte-offset-in-word width
- `word_size`, 2: word-in-block width
- `index_size`, 6: L1 set index width

Ports
- `clk_i`  in  1  clock; all state on rising edge
- `rst_ni`  in  1  asynchronous active-low reset
- `req_valid_i`  in  1  store request valid
- `req_ready_o`  out  1  block idle, can accept
- `store_instruction_i`  in  3  funct3: SB=000, SH=001, SW=010, SD=011
- `index_i`  in  `index_size`  target set
- `word_i`  in  `word_size`  word within block
- `offset_i`  in  `offset_size`  byte within word
- `store_data_i`  in  64  data, LSB-aligned
- `rd_en_o`  out  1  array read strobe
- `rd_index_o`  out  `index_size`  read set
- `rd_data_i`  in  128  block, valid exactly 1 cycle after `rd_en_o`
- `wr_en_o`  out  1  array write strobe
- `wr_index_o`  out  `index_size`  write set
- `wr_block_o`  out  128  merged block
- `wr_byte_en_o`  out  16  bytes modified (for dirty tracking)
- `done_o`  out  1  one-cycle completion pulse
- `err_o`  out  1  with `done_o`: request was illegal, nothing written

## Operation
- Byte address `ba = {word_i, offset_i}` (0..15); size = 1/2/4/8 for SB/SH/SW/SD.
- Legality: SB any `ba`; SH needs `ba <= 14` (offset 11 with word ≠ 11 spans words, allowed); SW needs `offset_i == 0`; SD needs `offset_i == 0` and `word_i != 11`; funct3 outside 000–011 illegal.
- Merge: bytes `ba .. ba+size-1` of the block take `store_data_i[8*size-1:0]` LSB-first; all other bytes keep `rd_data_i`; `wr_byte_en_o` has exactly those bits set.
- FSM states IDLE, READ, CAPTURE, WRITE, ERROR.
  - IDLE: `req_ready_o = 1`; on `req_valid_i`, register all request fields; go READ if legal, else ERROR.
  - READ: `rd_en_o = 1`, `rd_index_o` = registered index -> CAPTURE.
  - CAPTURE: register `rd_data_i` and merged block -> WRITE.
  - WRITE: `wr_en_o = 1`, `done_o = 1` -> IDLE.
  - ERROR: `done_o = 1`, `err_o = 1`, no array strobes -> IDLE.
- Inputs are sampled only at acceptance; later changes are ignored.

## Timing
- Reset: state IDLE; `req_ready_o = 1`; every other output 0, including all data and index buses.
- Legal store: accept at edge 0, `rd_en_o` in cycle 1, data captured at end of cycle 2, `wr_en_o` and `done_o` in cycle 3. One store per 4 cycles.
- Illegal store: `done_o` and `err_o` in cycle 1. One store per 2 cycles.
- `req_ready_o` is low in every non-IDLE state; `req_valid_i` is ignored there.
- `wr_index_o` equals `rd_index_o` for the same request. Outputs are registered/decoded from state only, with no combinational path from request inputs.
- Reset asserted mid-operation: immediately IDLE; any pending write is dropped and `wr_en_o` drops the same cycle.
- Back-to-back stores to the same set are coherent, because the write completes before the next acceptance.

## Structure
- Package `cache_store_pkg`: funct3 constants SB/SH/SW/SD, state enum, `BLOCK_BYTES = 16`.
- Sub-module `cache_store_merge`: combinational; inputs old block, data, `ba`, size; outputs merged block, byte enables, legality.
- Top holds the FSM and registers only.

## Test plan
- SB: block all 0x00, word=2, offset=1, data 0xAB -> `wr_byte_en_o` = 0x0200; byte 9 = 0xAB, all else 0; `done_o` in cycle 3.
- SH crossing words: block all 0xFF, word=0, offset=3, data 0x1234 -> bytes 3,4 = 0x34,0x12; `wr_byte_en_o` = 0x0018.
- SD: word=1, data 0x0123456789ABCDEF -> bytes 4..11 written LSB-first; `wr_byte_en_o` = 0x0FF0; bytes 0–3 and 12–15 unchanged.
- Illegal requests (SW with offset 01, SD with word 11, funct3 = 100) -> `done_o`/`err_o` in cycle 1; `rd_en_o` and `wr_en_o` never asserted.
- Two same-set SB back-to-back with `req_valid_i` held high -> second accepted only after first `done_o`; second read returns first write's data; both bytes present at the end.
- `rst_ni` low during CAPTURE -> no `wr_en_o`; `req_ready_o = 1` after release.

Source files
------------

// File: rtl/cache_store_l1_data_pkg.sv
// Shared definitions for the L1 store read-modify-write block:
// funct3 store encodings, FSM states and block geometry.
package cache_store_pkg;

  localparam int BLOCK_BYTES = 16;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_WRITE,
    S_ERROR
  } state_e;

endpackage

// File: rtl/cache_store_l1_data_merge.sv
// Combinational store merge: decides legality of a store at byte address ba
// and overlays the LSB-aligned store data onto the old 128-bit block.
module cache_store_merge
  import cache_store_pkg::*;
(
  input  logic [127:0] block_i,
  input  logic [63:0]  data_i,
  input  logic [3:0]   ba_i,
  input  logic [2:0]   funct3_i,
  output logic [127:0] block_o,
  output logic [15:0]  byte_en_o,
  output logic         legal_o
);

  logic [3:0] size;
  logic [4:0] idx;

  always_comb begin
    size    = 4'd0;
    legal_o = 1'b0;
    case (funct3_i)
      F3_SB: begin
        size    = 4'd1;
        legal_o = 1'b1;
      end
      F3_SH: begin
        size    = 4'd2;
        legal_o = (ba_i != 4'd15);
      end
      F3_SW: begin
        size    = 4'd4;
        legal_o = (ba_i[1:0] == 2'b00);
      end
      F3_SD: begin
        size    = 4'd8;
        legal_o = (ba_i[1:0] == 2'b00) && (ba_i[3:2] != 2'b11);
      end
      default: ;
    endcase

    // Store byte k lands at block byte ba+k; an illegal store leaves the block untouched.
    block_o   = block_i;
    byte_en_o = '0;
    idx       = '0;
    for (int k = 0; k < 8; k++) begin
      idx = {1'b0, ba_i} + 5'(k);
      if (legal_o && (4'(k) < size) && (idx < 5'(BLOCK_BYTES))) begin
        block_o[{idx[3:0], 3'b000} +: 8] = data_i[{3'(k), 3'b000} +: 8];
        byte_en_o[idx[3:0]]              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_store_l1_data.sv
// L1 store path: accepts one SB/SH/SW/SD, reads the addressed block, merges
// the store bytes and writes the block back with per-byte enables.
module cache_store_l1_data
  import cache_store_pkg::*;
#(
  parameter int offset_size = 2,
  parameter int word_size   = 2,
  parameter int index_size  = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [2:0]             store_instruction_i,
  input  logic [index_size-1:0]  index_i,
  input  logic [word_size-1:0]   word_i,
  input  logic [offset_size-1:0] offset_i,
  input  logic [63:0]            store_data_i,
  output logic                   rd_en_o,
  output logic [index_size-1:0]  rd_index_o,
  input  logic [127:0]           rd_data_i,
  output logic                   wr_en_o,
  output logic [index_size-1:0]  wr_index_o,
  output logic [127:0]           wr_block_o,
  output logic [15:0]            wr_byte_en_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int BA_W = word_size + offset_size;

  state_e state_q, state_d;

  logic [2:0]            funct3_q;
  logic [index_size-1:0] index_q;
  logic [BA_W-1:0]       ba_q;
  logic [63:0]           data_q;
  logic [127:0]          block_q;
  logic [15:0]           byte_en_q;

  logic [BA_W-1:0] ba_in;
  logic [BA_W-1:0] ba_sel;
  logic [2:0]      funct3_sel;
  logic [127:0]    merged;
  logic [15:0]     merged_be;
  logic            legal;
  logic            accept;

  // One merge unit serves both uses: legality of the live request while idle,
  // and the actual merge of the registered request against the read data.
  assign ba_in      = {word_i, offset_i};
  assign ba_sel     = (state_q == S_IDLE) ? ba_in : ba_q;
  assign funct3_sel = (state_q == S_IDLE) ? store_instruction_i : funct3_q;

  cache_store_merge u_merge (
    .block_i   (rd_data_i),
    .data_i    (data_q),
    .ba_i      (ba_sel),
    .funct3_i  (funct3_sel),
    .block_o   (merged),
    .byte_en_o (merged_be),
    .legal_o   (legal)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rd_en_o     = 1'b0;
    wr_en_o     = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    accept      = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          accept  = 1'b1;
          state_d = legal ? S_READ : S_ERROR;
        end
      end
      S_READ: begin
        rd_en_o = 1'b1;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        wr_en_o = 1'b1;
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERROR: begin
        done_o  = 1'b1;
        err_o   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Data registers are cleared too so every output bus reads zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      funct3_q  <= '0;
      index_q   <= '0;
      ba_q      <= '0;
      data_q    <= '0;
      block_q   <= '0;
      byte_en_q <= '0;
    end else begin
      if (accept) begin
        funct3_q <= store_instruction_i;
        index_q  <= index_i;
        ba_q     <= ba_in;
        data_q   <= store_data_i;
      end
      if (state_q == S_CAPTURE) begin
        block_q   <= merged;
        byte_en_q <= merged_be;
      end
    end
  end

  assign rd_index_o   = index_q;
  assign wr_index_o   = index_q;
  assign wr_block_o   = block_q;
  assign wr_byte_en_o = byte_en_q;

endmodule

// File: tb/tb_cache_store_l1_data.sv
// Bench for cache_store_l1_data: directed and random stores against a
// byte-level reference memory, with a behavioural L1 array model around the DUT.
module tb_cache_store_l1_data;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   f3;
  logic [5:0]   idx;
  logic [1:0]   word;
  logic [1:0]   off;
  logic [63:0]  sdata;
  logic         rd_en;
  logic [5:0]   rd_index;
  logic [127:0] rd_data;
  logic         wr_en;
  logic [5:0]   wr_index;
  logic [127:0] wr_block;
  logic [15:0]  wr_be;
  logic         done;
  logic         err;

  bit   [127:0] mem     [64];
  bit   [127:0] ref_mem [64];
  logic         pre_en;
  logic [5:0]   pre_idx;
  logic [127:0] pre_val;
  logic [127:0] last_blk;
  logic [15:0]  last_be;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cache_store_l1_data dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .req_valid_i         (req_valid),
    .req_ready_o         (req_ready),
    .store_instruction_i (f3),
    .index_i             (idx),
    .word_i              (word),
    .offset_i            (off),
    .store_data_i        (sdata),
    .rd_en_o             (rd_en),
    .rd_index_o          (rd_index),
    .rd_data_i           (rd_data),
    .wr_en_o             (wr_en),
    .wr_index_o          (wr_index),
    .wr_block_o          (wr_block),
    .wr_byte_en_o        (wr_be),
    .done_o              (done),
    .err_o               (err)
  );

  // L1 array model: read data one cycle after rd_en, garbage otherwise.
  always @(posedge clk) begin
    rd_data <= rd_en ? mem[rd_index] : {$urandom, $urandom, $urandom, $urandom};
    if (wr_en) begin
      for (int b = 0; b < 16; b++)
        if (wr_be[b]) mem[wr_index][8*b +: 8] <= wr_block[8*b +: 8];
    end
    if (pre_en) mem[pre_idx] <= pre_val;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_legal(input logic [2:0] fn, input int ba);
    int size;
    if (fn > 3'd3) return 1'b0;
    size = 1 << fn;
    if (ba + size > 16) return 1'b0;
    if (size >= 4 && (ba % 4) != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic ref_merge(input logic [127:0] old, input logic [2:0] fn, input int ba,
                           input logic [63:0] d, output logic [127:0] blk, output logic [15:0] be);
    int size;
    size = 1 << fn;
    blk  = old;
    be   = '0;
    for (int i = 0; i < 16; i++) begin
      if (i >= ba && i < ba + size) begin
        blk[8*i +: 8] = 8'(d >> (8 * (i - ba)));
        be[i]         = 1'b1;
      end
    end
  endtask

  task automatic preload(input logic [5:0] i, input logic [127:0] v);
    @(negedge clk);
    pre_en     = 1'b1;
    pre_idx    = i;
    pre_val    = v;
    ref_mem[i] = v;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic scramble_inputs();
    f3        = 3'($urandom);
    idx       = 6'($urandom);
    word      = 2'($urandom);
    off       = 2'($urandom);
    sdata     = {$urandom, $urandom};
    req_valid = 1'($urandom_range(0, 1));
  endtask

  task automatic run_store(input logic [2:0] f3_v, input logic [5:0] idx_v, input logic [1:0] w_v,
                           input logic [1:0] o_v, input logic [63:0] d_v);
    int ba;
    int waited;
    logic [127:0] eb;
    logic [15:0]  ebe;
    ba     = int'({w_v, o_v});
    waited = 0;
    while (!req_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_before", 128'(req_ready), 128'(1));
    req_valid = 1'b1;
    f3 = f3_v; idx = idx_v; word = w_v; off = o_v; sdata = d_v;
    @(posedge clk);
    #1;
    scramble_inputs();
    @(negedge clk);
    if (ref_legal(f3_v, ba)) begin
      chk("c1_rd_en", 128'(rd_en), 128'(1));
      chk("c1_rd_index", 128'(rd_index), 128'(idx_v));
      chk("c1_ready", 128'(req_ready), 128'(0));
      chk("c1_done", 128'(done), 128'(0));
      @(negedge clk);
      chk("c2_strobes", 128'({rd_en, wr_en, done}), 128'(0));
      ref_merge(ref_mem[idx_v], f3_v, ba, d_v, eb, ebe);
      @(negedge clk);
      chk("c3_wr_done_err", 128'({wr_en, done, err}), 128'(3'b110));
      chk("c3_wr_index", 128'(wr_index), 128'(idx_v));
      chk("c3_wr_block", wr_block, eb);
      chk("c3_wr_be", 128'(wr_be), 128'(ebe));
      last_blk = wr_block;
      last_be  = wr_be;
      ref_mem[idx_v] = eb;
    end else begin
      chk("err_done_err", 128'({done, err}), 128'(2'b11));
      chk("err_no_strobe", 128'({rd_en, wr_en}), 128'(0));
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("idle_ready", 128'(req_ready), 128'(1));
    chk("idle_done", 128'(done), 128'(0));
  endtask

  initial begin
    logic [127:0] eb;
    logic [15:0]  ebe;
    logic [2:0]   rf3;

    rst_n = 1'b0; req_valid = 1'b0; f3 = '0; idx = '0; word = '0; off = '0; sdata = '0;
    pre_en = 1'b0; pre_idx = '0; pre_val = '0;
    #12;
    chk("rst_ready", 128'(req_ready), 128'(1));
    chk("rst_strobes", 128'({rd_en, wr_en, done, err}), 128'(0));
    chk("rst_indices", 128'({rd_index, wr_index}), 128'(0));
    chk("rst_wr_block", wr_block, 128'(0));
    chk("rst_wr_be", 128'(wr_be), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // SB into a zero block
    preload(6'd1, 128'h0);
    run_store(3'b000, 6'd1, 2'd2, 2'd1, 64'hAB);
    chk("sb_be_const", 128'(last_be), 128'(16'h0200));
    chk("sb_blk_const", last_blk, 128'hAB << 72);

    // SH crossing a word boundary into an all-ones block
    preload(6'd2, ~128'h0);
    run_store(3'b001, 6'd2, 2'd0, 2'd3, 64'h1234);
    chk("sh_be_const", 128'(last_be), 128'(16'h0018));
    chk("sh_blk_const", last_blk, (~128'h0 & ~(128'hFFFF << 24)) | (128'h1234 << 24));

    // SD into word 1
    preload(6'd3, 128'h00112233445566778899AABBCCDDEEFF);
    run_store(3'b011, 6'd3, 2'd1, 2'd0, 64'h0123456789ABCDEF);
    chk("sd_be_const", 128'(last_be), 128'(16'h0FF0));
    chk("sd_blk_const", last_blk, 128'h00112233_0123456789ABCDEF_CCDDEEFF);

    // Illegal requests
    run_store(3'b010, 6'd4, 2'd1, 2'd1, 64'hDEAD);
    run_store(3'b011, 6'd4, 2'd3, 2'd0, 64'hBEEF);
    run_store(3'b100, 6'd4, 2'd0, 2'd0, 64'hCAFE);
    chk("illegal_no_write", mem[4], ref_mem[4]);

    // Back-to-back same-set SB with valid held high
    preload(6'd5, 128'h0);
    req_valid = 1'b1; f3 = 3'b000; idx = 6'd5; word = 2'd0; off = 2'd0; sdata = 64'hAA;
    @(posedge clk);
    #1;
    word = 2'd3; off = 2'd3; sdata = 64'h55;
    @(negedge clk);
    chk("b2b_c1", 128'({req_ready, rd_en}), 128'(2'b01));
    @(negedge clk);
    chk("b2b_c2_ready", 128'(req_ready), 128'(0));
    @(negedge clk);
    ref_merge(ref_mem[5], 3'b000, 0, 64'hAA, eb, ebe);
    ref_mem[5] = eb;
    chk("b2b_c3_done", 128'({req_ready, wr_en, done}), 128'(3'b011));
    chk("b2b_first_blk", wr_block, eb);
    @(negedge clk);
    chk("b2b_c4_ready", 128'(req_ready), 128'(1));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_c5_rd", 128'(rd_en), 128'(1));
    @(negedge clk);
    @(negedge clk);
    ref_merge(ref_mem[5], 3'b000, 15, 64'h55, eb, ebe);
    ref_mem[5] = eb;
    chk("b2b_second_done", 128'({wr_en, done}), 128'(2'b11));
    chk("b2b_second_blk", wr_block, (128'h55 << 120) | 128'hAA);
    chk("b2b_second_be", 128'(wr_be), 128'(ebe));
    @(negedge clk);

    // Reset asserted during CAPTURE drops the write
    preload(6'd6, 128'h0F0E0D0C0B0A09080706050403020100);
    req_valid = 1'b1; f3 = 3'b010; idx = 6'd6; word = 2'd1; off = 2'd0; sdata = 64'h11223344;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wr_en", 128'(wr_en), 128'(0));
    chk("rst_mid_ready", 128'(req_ready), 128'(1));
    @(negedge clk);
    chk("rst_mid_hold", 128'({wr_en, done, rd_en}), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_after", 128'({req_ready, wr_en}), 128'(2'b10));
    chk("rst_mid_mem", mem[6], ref_mem[6]);

    // Random stores over a few sets to exercise read-after-write
    for (int s = 0; s < 4; s++) preload(6'(s), {$urandom, $urandom, $urandom, $urandom});
    for (int n = 0; n < 80; n++) begin
      rf3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      run_store(rf3, 6'($urandom_range(0, 3)), 2'($urandom), 2'($urandom), {$urandom, $urandom});
    end
    for (int s = 0; s < 7; s++) chk("final_mem", mem[s], ref_mem[s]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
